// File: rtl/exc_flush_ctrl_if.sv
// WB/CP0/fetch-side signal bundle for the exception flush sequencer.
// The slave modport is the sequencer's view of the bundle; master is the pipeline's view.
interface exc_flush_ctrl_if;
    logic        ws_valid;
    logic        ws_ex;
    logic [4:0]  ws_excode;
    logic [31:0] ws_pc;
    logic        ws_bd;
    logic [31:0] ws_badvaddr;
    logic        ws_eret;
    logic        int_pending;
    logic        cp0_exl;
    logic [31:0] cp0_epc;
    logic        fs_redirect_ack;
    logic        ws_kill;
    logic        pipe_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        cp0_exc_we;
    logic [4:0]  cp0_exc_code;
    logic        cp0_exc_bd;
    logic        cp0_epc_we;
    logic [31:0] cp0_exc_epc;
    logic        cp0_badvaddr_we;
    logic [31:0] cp0_badvaddr;
    logic        cp0_eret_we;
    logic        busy;

    modport slave (
        input  ws_valid, ws_ex, ws_excode, ws_pc, ws_bd, ws_badvaddr, ws_eret,
               int_pending, cp0_exl, cp0_epc, fs_redirect_ack,
        output ws_kill, pipe_flush, redirect_valid, redirect_pc,
               cp0_exc_we, cp0_exc_code, cp0_exc_bd, cp0_epc_we, cp0_exc_epc,
               cp0_badvaddr_we, cp0_badvaddr, cp0_eret_we, busy
    );

    modport master (
        output ws_valid, ws_ex, ws_excode, ws_pc, ws_bd, ws_badvaddr, ws_eret,
               int_pending, cp0_exl, cp0_epc, fs_redirect_ack,
        input  ws_kill, pipe_flush, redirect_valid, redirect_pc,
               cp0_exc_we, cp0_exc_code, cp0_exc_bd, cp0_epc_we, cp0_exc_epc,
               cp0_badvaddr_we, cp0_badvaddr, cp0_eret_we, busy
    );
endinterface

// File: rtl/exc_flush_ctrl.sv
// Exception/interrupt/ERET commit sequencer: kills WB, flushes the pipe for
// FLUSH_CYCLES, strobes CP0 once, then holds a redirect to fetch until acked.
module exc_flush_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             resetn,
    exc_flush_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_REDIR = 2'd2;

    localparam logic [1:0] K_INT  = 2'd0;
    localparam logic [1:0] K_EXC  = 2'd1;
    localparam logic [1:0] K_ERET = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        first_q, first_d;
    logic [1:0]  kind_q, kind_d;
    logic [4:0]  code_q, code_d;
    logic        bd_q, bd_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badv_q, badv_d;
    logic        exl_q, exl_d;
    logic [31:0] target_q, target_d;

    logic idle;
    logic evt;

    assign idle = (state_q == S_IDLE);
    assign evt  = bus.ws_valid & (bus.int_pending | bus.ws_ex | bus.ws_eret);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        first_d  = 1'b0;
        kind_d   = kind_q;
        code_d   = code_q;
        bd_d     = bd_q;
        epc_d    = epc_q;
        badv_d   = badv_q;
        exl_d    = exl_q;
        target_d = target_q;
        case (state_q)
            S_IDLE: begin
                if (evt) begin
                    state_d  = S_FLUSH;
                    cnt_d    = CNT_INIT;
                    first_d  = 1'b1;
                    bd_d     = bus.ws_bd;
                    epc_d    = bus.ws_bd ? bus.ws_pc - 32'd4 : bus.ws_pc;
                    badv_d   = bus.ws_badvaddr;
                    exl_d    = bus.cp0_exl;
                    // Interrupt outranks a WB exception, which outranks ERET.
                    if (bus.int_pending) begin
                        kind_d   = K_INT;
                        code_d   = 5'd0;
                        target_d = EXC_VECTOR;
                    end else if (bus.ws_ex) begin
                        kind_d   = K_EXC;
                        code_d   = bus.ws_excode;
                        target_d = EXC_VECTOR;
                    end else begin
                        kind_d   = K_ERET;
                        code_d   = 5'd0;
                        target_d = bus.cp0_epc;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q == 4'd0) state_d = S_REDIR;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_REDIR: begin
                if (bus.fs_redirect_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            first_q  <= 1'b0;
            kind_q   <= K_INT;
            code_q   <= 5'd0;
            bd_q     <= 1'b0;
            epc_q    <= 32'd0;
            badv_q   <= 32'd0;
            exl_q    <= 1'b0;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            kind_q   <= kind_d;
            code_q   <= code_d;
            bd_q     <= bd_d;
            epc_q    <= epc_d;
            badv_q   <= badv_d;
            exl_q    <= exl_d;
            target_q <= target_d;
        end
    end

    // Kill is gated by reset so every output reads 0 while reset is held.
    assign bus.ws_kill         = resetn & (idle ? evt : 1'b1);
    assign bus.pipe_flush      = ~idle;
    assign bus.busy            = ~idle;
    assign bus.redirect_valid  = (state_q == S_REDIR);
    assign bus.redirect_pc     = target_q;

    // A nested exception (EXL already set) must not overwrite EPC.
    assign bus.cp0_exc_we      = first_q & (kind_q != K_ERET);
    assign bus.cp0_epc_we      = first_q & (kind_q != K_ERET) & ~exl_q;
    assign bus.cp0_badvaddr_we = first_q & (kind_q == K_EXC) &
                                 ((code_q == 5'd4) | (code_q == 5'd5));
    assign bus.cp0_eret_we     = first_q & (kind_q == K_ERET);
    assign bus.cp0_exc_code    = code_q;
    assign bus.cp0_exc_bd      = bd_q;
    assign bus.cp0_exc_epc     = epc_q;
    assign bus.cp0_badvaddr    = badv_q;
endmodule

// File: doc/exc_flush_ctrl.md
# exc_flush_ctrl

Exception/ERET commit sequencer at the write-back end of the 5-stage MIPS pipeline. It detects a committing exception, interrupt or ERET in WB and kills that instruction's write-back. It then holds a pipeline-wide flush for a programmable number of cycles, issues the CP0 update strobes, and steers fetch to the exception vector or EPC through a held redirect handshake. It is the single owner of pipeline flush and of the exception redirect to the fetch stage.

## Interface
Parameters:
- EXC_VECTOR, 32'hbfc00380, target PC for every exception and interrupt.
- FLUSH_CYCLES, 1, number of cycles pipe_flush is asserted before the redirect is offered; legal range 1..15.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ws_valid  in  1  WB holds a valid instruction this cycle.
- ws_ex  in  1  WB instruction carries an exception.
- ws_excode  in  5  ExcCode of the WB exception.
- ws_pc  in  32  PC of the WB instruction.
- ws_bd  in  1  WB instruction sits in a branch delay slot.
- ws_badvaddr  in  32  faulting address, meaningful only when ws_excode is 4 or 5.
- ws_eret  in  1  WB instruction is ERET.
- int_pending  in  1  from CP0: Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- cp0_exl  in  1  current Status.EXL.
- cp0_epc  in  32  current EPC.
- fs_redirect_ack  in  1  fetch has accepted redirect_pc.
- ws_kill  out  1  combinational; suppresses RF and CP0 writes of the WB instruction.
- pipe_flush  out  1  invalidates all of IF, ID, EX and MEM.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  32  redirect target.
- cp0_exc_we  out  1  one-cycle strobe: write Cause.ExcCode and Cause.BD, set EXL.
- cp0_exc_code  out  5  ExcCode value for cp0_exc_we.
- cp0_exc_bd  out  1  BD value for cp0_exc_we.
- cp0_epc_we  out  1  one-cycle strobe: write EPC.
- cp0_exc_epc  out  32  EPC value for cp0_epc_we.
- cp0_badvaddr_we  out  1  one-cycle strobe: write BadVAddr.
- cp0_badvaddr  out  32  BadVAddr value.
- cp0_eret_we  out  1  one-cycle strobe: clear EXL.
- busy  out  1  asserted whenever the state is not IDLE.

## Operation
- States: IDLE, FLUSH, REDIRECT. A 4-bit counter runs in FLUSH.
- Event: evaluated only in IDLE. Event = ws_valid & (int_pending | ws_ex | ws_eret).
- Event priority: int_pending > ws_ex > ws_eret.
- ws_kill:
  - In IDLE, ws_kill = event, for all three event kinds.
  - In FLUSH and REDIRECT, ws_kill = 1.
- On an event, the following are captured into registers:
  - kind.
  - code: 0 for an interrupt; ws_excode for an exception.
  - bd: ws_bd.
  - epc: ws_bd ? ws_pc-4 : ws_pc, computed modulo 2^32.
  - badvaddr: ws_badvaddr.
  - exl_at_event: cp0_exl.
  - target: EXC_VECTOR for an interrupt or exception; cp0_epc for ERET.
- State transitions:
  - IDLE -> FLUSH on an event; the counter loads FLUSH_CYCLES-1.
  - FLUSH: the counter decrements each cycle; FLUSH -> REDIRECT when the counter is 0.
  - REDIRECT -> IDLE in the cycle fs_redirect_ack = 1.
- First FLUSH cycle only, one-cycle strobes:
  - Interrupt/exception: cp0_exc_we = 1.
  - cp0_epc_we = 1 only for an interrupt/exception with exl_at_event = 0, so a nested exception keeps EPC.
  - cp0_badvaddr_we = 1 only for an exception with code 4 or 5.
  - ERET: cp0_eret_we = 1 and no other CP0 strobes.
- pipe_flush = 1 in FLUSH and in REDIRECT.
- redirect_valid = 1 throughout REDIRECT. redirect_pc holds the captured target from capture until the next event.
- While busy, all ws_*, int_pending and cp0_* inputs are ignored.
- fs_redirect_ack outside REDIRECT is ignored.
- Asynchronous reset, including mid-sequence: state IDLE, counter 0, all outputs 0, redirect_pc 0. The first event after reset is handled normally.

## Timing
- Event at cycle T: ws_kill = 1 in T.
- pipe_flush = 1 from T+1 through the acknowledge cycle.
- CP0 strobes at T+1 only.
- redirect_valid = 1 from T+1+FLUSH_CYCLES until ack, inclusive.
- Ack at cycle A: state is IDLE at A+1, and pipe_flush and redirect_valid are 0 at A+1.
- Ack already high on the first REDIRECT cycle gives a 1-cycle REDIRECT.
- Minimum event-to-event spacing is FLUSH_CYCLES+2 cycles.
- No combinational path from fs_redirect_ack to any output.

## Test plan
- Syscall: ws_ex=1, code 8, pc 0xbfc00100, bd=0, exl=0, FLUSH_CYCLES=1, ack tied high.
  - T: ws_kill=1.
  - T+1: cp0_exc_we=1, code 8, cp0_epc_we=1, EPC 0xbfc00100.
  - T+2: redirect_valid=1, redirect_pc 0xbfc00380.
  - T+3: IDLE.
- Delay-slot AdEL: code 4, pc 0x1000, bd=1, badvaddr 0x3 -> EPC 0xffc, cp0_exc_bd=1, cp0_badvaddr_we=1, BadVAddr 0x3.
- ERET with cp0_epc 0x8000_0040 -> cp0_eret_we pulse, no exc/epc strobes, redirect_pc 0x80000040.
- Priority and nesting: int_pending=1 together with ws_ex=1 (code 10) and exl=1 -> code 0, cp0_epc_we=0.
- Held redirect, FLUSH_CYCLES=3: ack withheld for 5 cycles -> redirect_valid and pipe_flush stay 1 and pc stable; a second ws_ex during busy is ignored.
- Reset mid-sequence: resetn low during REDIRECT -> all outputs 0 immediately; after release, a new syscall is processed normally.
